// File: rtl/clock_gen_pkg.sv
// clock_gen_pkg: shared state encoding and limits for the programmable clock generator
`timescale 1ns/1ps
package clock_gen_pkg;
  typedef enum logic [1:0] {CH_IDLE, CH_RUN, CH_STOP} ch_state_t;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/clock_gen_channel.sv
// clock_gen_channel: one divided clock with tick strobe and glitch-free start/stop
`timescale 1ns/1ps
module clock_gen_channel
  import clock_gen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);
  ch_state_t        state;
  logic [DIV_W-1:0] cnt, per, hi, nxt, eff;
  logic             idle, start, halt, hi_nxt;
  assign eff     = (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
  assign hi      = per - (per >> 1);
  assign nxt     = cnt + 1'b1;
  assign hi_nxt  = nxt < hi;
  assign idle    = state == CH_IDLE;
  assign running = !idle;
  assign start   = en && (idle || cnt == per - 1'b1);
  // stopping is only immediate once the output is low; a high phase always finishes
  assign halt    = !idle && !en && (!clk_out || !hi_nxt);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CH_IDLE;
      cnt     <= '0;
      per     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (start) begin
      state   <= CH_RUN;
      cnt     <= '0;
      per     <= eff;
      clk_out <= 1'b1;
      tick    <= 1'b1;
    end else if (halt) begin
      state   <= CH_IDLE;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!idle) begin
      state   <= en ? CH_RUN : CH_STOP;
      cnt     <= nxt;
      clk_out <= hi_nxt;
      tick    <= 1'b0;
    end else begin
      tick    <= 1'b0;
    end
  end
endmodule

// File: rtl/multi_clock_gen.sv
// multi_clock_gen: NUM_CH independent programmable clock channels from one system clock
`timescale 1ns/1ps
module multi_clock_gen
  import clock_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*DIV_W-1:0] divide,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       running
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_gen_channel #(.DIV_W(DIV_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (enable[i]),
      .div     (divide[i*DIV_W +: DIV_W]),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .running (running[i])
    );
  end
endmodule

// File: tb/tb_multi_clock_gen.sv
// tb_multi_clock_gen: directed vectors with hand-computed waveforms for multi_clock_gen
`timescale 1ns/1ps
module tb_multi_clock_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  enable;
  logic [31:0] divide;
  logic [3:0]  clk_out, tick, running;
  int          n_vec = 0, n_bad = 0;

  multi_clock_gen #(.NUM_CH(4), .DIV_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .divide  (divide),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // steps n cycles, comparing channel ch against patterns read MSB-first
  task automatic seq(input string tag, input int ch, input int n,
                     input logic [15:0] cp, input logic [15:0] tp, input logic [15:0] rp);
    for (int i = n - 1; i >= 0; i--) begin
      step();
      chk({tag, ".clk"}, 32'(clk_out[ch]), 32'(cp[i]));
      chk({tag, ".tick"}, 32'(tick[ch]), 32'(tp[i]));
      chk({tag, ".run"}, 32'(running[ch]), 32'(rp[i]));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = '0;
    divide = '0;
    #20;
    chk("rst.clk", 32'(clk_out), 0);
    chk("rst.tick", 32'(tick), 0);
    chk("rst.run", 32'(running), 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle.clk", 32'(clk_out), 0);
      chk("idle.tick", 32'(tick), 0);
      chk("idle.run", 32'(running), 0);
    end
    divide[7:0] = 8'd4;
    enable[0]   = 1'b1;
    seq("div4", 0, 8, 16'b11001100, 16'b10001000, 16'b11111111);
    enable[0] = 1'b0;
    step();
    chk("div4.off", 32'(running), 0);
    divide[15:8]  = 8'd5;
    divide[23:16] = 8'd0;
    enable[2:1]   = 2'b11;
    for (int i = 9; i >= 0; i--) begin
      logic [9:0] c1, t1, c2;
      c1 = 10'b1110011100;
      t1 = 10'b1000010000;
      c2 = 10'b1010101010;
      step();
      chk("div5.clk", 32'(clk_out[1]), 32'(c1[i]));
      chk("div5.tick", 32'(tick[1]), 32'(t1[i]));
      chk("div0.clk", 32'(clk_out[2]), 32'(c2[i]));
      chk("div0.tick", 32'(tick[2]), 32'(c2[i]));
      chk("ch0.quiet", 32'(clk_out[0]), 0);
    end
    enable[2:1] = 2'b00;
    step();
    chk("ch12.off", 32'(running), 0);
    divide[7:0] = 8'd8;
    enable[0]   = 1'b1;
    seq("stop8a", 0, 1, 16'b1, 16'b1, 16'b1);
    enable[0] = 1'b0;
    seq("stop8b", 0, 5, 16'b11100, 16'b00000, 16'b11100);
    step();
    chk("stop8.hold", 32'(clk_out[0]), 0);
    divide[7:0] = 8'd4;
    enable[0]   = 1'b1;
    seq("chg4", 0, 1, 16'b1, 16'b1, 16'b1);
    divide[7:0] = 8'd6;
    seq("chg6", 0, 10, 16'b1001110001, 16'b0001000001, 16'b1111111111);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.clk", 32'(clk_out), 0);
    chk("arst.run", 32'(running), 0);
    chk("arst.tick", 32'(tick), 0);
    #1 rst_n = 1'b1;
    seq("restart", 0, 6, 16'b111000, 16'b100000, 16'b111111);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
